// File: rtl/alu_uart_host_if.sv
// Host-side bundle for alu_uart_host: request/operands in,
// serial link to the ALU target and result/status out.
interface alu_uart_host_if #(
    parameter int N_DATA       = 8,
    parameter int NB_OPERATION = 6
);
    logic                    i_tick;
    logic                    i_start;
    logic [N_DATA-1:0]       i_data_a;
    logic [N_DATA-1:0]       i_data_b;
    logic [NB_OPERATION-1:0] i_op;
    logic                    i_rx;
    logic                    o_tx;
    logic                    o_busy;
    logic                    o_done;
    logic [N_DATA-1:0]       o_result;
    logic                    o_error;

    modport master (
        output i_tick, i_start, i_data_a, i_data_b, i_op, i_rx,
        input  o_tx, o_busy, o_done, o_result, o_error
    );

    modport slave (
        input  i_tick, i_start, i_data_a, i_data_b, i_op, i_rx,
        output o_tx, o_busy, o_done, o_result, o_error
    );
endinterface

// File: rtl/alu_uart_host.sv
// UART host for a remote ALU: sends A, B and opcode as 8N1 frames,
// then waits (with timeout) for a one-byte result frame.
module alu_uart_host #(
    parameter int N_DATA        = 8,
    parameter int NB_OPERATION  = 6,
    parameter int N_OVERSAMPLE  = 16,
    parameter int TIMEOUT_TICKS = 4096
) (
    input  logic          i_clk,
    input  logic          i_rst,
    alu_uart_host_if.slave bus
);
    localparam int TW = $clog2(N_OVERSAMPLE);
    localparam int BW = $clog2(N_DATA + 2);
    localparam int CW = $clog2(TIMEOUT_TICKS + 1);

    localparam logic [TW-1:0] TICK_LAST = TW'(N_OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_MID  = TW'(N_OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0] BIT_DEND  = BW'(N_DATA);
    localparam logic [BW-1:0] BIT_STOP  = BW'(N_DATA + 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE,
        SEND_A,
        SEND_B,
        SEND_OP,
        WAIT_RES,
        RECV,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [TW-1:0]           tick_q, tick_d;
    logic [BW-1:0]           bit_q, bit_d;
    logic [CW-1:0]           to_q, to_d;
    logic [N_DATA-1:0]       sh_q, sh_d;
    logic [N_DATA-1:0]       b_q, b_d;
    logic [NB_OPERATION-1:0] op_q, op_d;
    logic [N_DATA-1:0]       rsh_q, rsh_d;
    logic [N_DATA-1:0]       res_q, res_d;
    logic                    err_q, err_d;
    logic                    tx_q, tx_d;
    logic                    rx_meta_q, rx_sync_q;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q   <= IDLE;
            tick_q    <= '0;
            bit_q     <= '0;
            to_q      <= '0;
            sh_q      <= '0;
            b_q       <= '0;
            op_q      <= '0;
            rsh_q     <= '0;
            res_q     <= '0;
            err_q     <= 1'b0;
            tx_q      <= 1'b1;
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            to_q      <= to_d;
            sh_q      <= sh_d;
            b_q       <= b_d;
            op_q      <= op_d;
            rsh_q     <= rsh_d;
            res_q     <= res_d;
            err_q     <= err_d;
            tx_q      <= tx_d;
            rx_meta_q <= bus.i_rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        to_d    = to_q;
        sh_d    = sh_q;
        b_d     = b_q;
        op_d    = op_q;
        rsh_d   = rsh_q;
        res_d   = res_q;
        err_d   = err_q;
        tx_d    = tx_q;
        unique case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    state_d = SEND_A;
                    sh_d    = bus.i_data_a;
                    b_d     = bus.i_data_b;
                    op_d    = bus.i_op;
                    tx_d    = 1'b0;
                    tick_d  = '0;
                    bit_d   = '0;
                    to_d    = '0;
                end
            end
            SEND_A, SEND_B, SEND_OP: begin
                if (bus.i_tick) begin
                    if (tick_q != TICK_LAST) begin
                        tick_d = tick_q + 1'b1;
                    end else begin
                        tick_d = '0;
                        if (bit_q < BIT_DEND) begin
                            tx_d  = sh_q[0];
                            sh_d  = sh_q >> 1;
                            bit_d = bit_q + 1'b1;
                        end else if (bit_q == BIT_DEND) begin
                            tx_d  = 1'b1;
                            bit_d = bit_q + 1'b1;
                        end else begin
                            // stop bit done: next start bit follows at once
                            bit_d = '0;
                            tx_d  = 1'b0;
                            if (state_q == SEND_A) begin
                                state_d = SEND_B;
                                sh_d    = b_q;
                            end else if (state_q == SEND_B) begin
                                state_d = SEND_OP;
                                sh_d    = N_DATA'(op_q);
                            end else begin
                                state_d = WAIT_RES;
                                tx_d    = 1'b1;
                                to_d    = '0;
                            end
                        end
                    end
                end
            end
            WAIT_RES: begin
                if (bus.i_tick) begin
                    to_d = to_q + 1'b1;
                    if (!rx_sync_q) begin
                        state_d = RECV;
                        tick_d  = '0;
                        bit_d   = '0;
                    end else if (to_q == TO_LAST) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            RECV: begin
                if (bus.i_tick) begin
                    if (bit_q == '0) begin
                        // mid start bit: a high line means it was a glitch
                        if (tick_q == TICK_MID) begin
                            tick_d = '0;
                            if (rx_sync_q) begin
                                state_d = WAIT_RES;
                            end else begin
                                bit_d = bit_q + 1'b1;
                            end
                        end else begin
                            tick_d = tick_q + 1'b1;
                        end
                    end else if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        if (bit_q == BIT_STOP) begin
                            state_d = DONE;
                            err_d   = !rx_sync_q;
                            if (rx_sync_q) begin
                                res_d = rsh_q;
                            end
                        end else begin
                            rsh_d = {rx_sync_q, rsh_q[N_DATA-1:1]};
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.o_tx     = tx_q;
    assign bus.o_busy   = (state_q != IDLE);
    assign bus.o_done   = (state_q == DONE);
    assign bus.o_result = res_q;
    assign bus.o_error  = err_q;
endmodule

// File: tb/tb_alu_uart_host.sv
// Directed bench for alu_uart_host with tx/result scoreboards;
// i_tick is held high except for a deliberate hold window.
module tb_alu_uart_host;
    localparam int NB    = 8;
    localparam int NOP   = 6;
    localparam int NOS   = 16;
    localparam int TO    = 4096;
    localparam int FRAME = 10 * NOS;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_uart_host_if #(.N_DATA(NB), .NB_OPERATION(NOP)) bus_if ();

    alu_uart_host #(
        .N_DATA(NB),
        .NB_OPERATION(NOP),
        .N_OVERSAMPLE(NOS),
        .TIMEOUT_TICKS(TO)
    ) dut (
        .i_clk(clk),
        .i_rst(rst_n),
        .bus  (bus_if)
    );

    int n_pass  = 0;
    int n_total = 0;
    logic [7:0] exp_tx [$];
    logic [8:0] exp_res [$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic on_done();
        logic [8:0] e;
        check("sb_pending", 32'(exp_res.size()), 1);
        e = (exp_res.size() > 0) ? exp_res.pop_front() : 9'h1ff;
        check("done_pulse", bus_if.o_done, 1);
        check("done_error", bus_if.o_error, e[8]);
        check("done_result", bus_if.o_result, e[7:0]);
        check("done_busy", bus_if.o_busy, 1);
    endtask

    task automatic start_txn(input logic [7:0] a, input logic [7:0] b,
                             input logic [5:0] op);
        exp_tx.push_back(a);
        exp_tx.push_back(b);
        exp_tx.push_back(8'(op));
        bus_if.i_data_a = a;
        bus_if.i_data_b = b;
        bus_if.i_op     = op;
        bus_if.i_start  = 1'b1;
        step();
        bus_if.i_start  = 1'b0;
        bus_if.i_data_a = 8'($urandom);
        bus_if.i_data_b = 8'($urandom);
        bus_if.i_op     = 6'($urandom);
        check("accept_busy", bus_if.o_busy, 1);
    endtask

    task automatic collect_tx(input int pulse_at);
        logic [29:0] st;
        logic [7:0]  a, b, o;
        logic [7:0]  obs [3];
        int          bad, bi;
        a = exp_tx.pop_front();
        b = exp_tx.pop_front();
        o = exp_tx.pop_front();
        st = {1'b1, o, 1'b0, 1'b1, b, 1'b0, 1'b1, a, 1'b0};
        for (int k = 0; k < 3; k++) obs[k] = 8'h00;
        bad = 0;
        for (int c = 0; c < 3 * FRAME; c++) begin
            bus_if.i_start = (c == pulse_at);
            if (c == pulse_at) bus_if.i_data_a = 8'($urandom);
            if (bus_if.o_tx !== st[c / NOS]) bad++;
            bi = (c / NOS) % 10;
            if ((c % NOS) == NOS / 2 && bi >= 1 && bi <= 8)
                obs[(c / NOS) / 10][bi - 1] = bus_if.o_tx;
            step();
        end
        bus_if.i_start = 1'b0;
        check("tx_byte_a", obs[0], a);
        check("tx_byte_b", obs[1], b);
        check("tx_byte_op", obs[2], o);
        check("tx_bit_cycles", bad, 0);
        check("tx_idle_after_op", bus_if.o_tx, 1);
        check("wait_busy", bus_if.o_busy, 1);
    endtask

    task automatic reply(input logic [7:0] val, input logic stopb,
                         input int extra);
        logic [9:0] fr;
        int         done_at;
        fr = {stopb, val, 1'b0};
        done_at = -1;
        for (int i = 0; i < FRAME + extra; i++) begin
            bus_if.i_rx = (i < FRAME) ? fr[i / NOS] : 1'b1;
            step();
            if (done_at >= 0 && i == done_at + 1) begin
                check("post_done_low", bus_if.o_done, 0);
                check("post_busy_low", bus_if.o_busy, 0);
            end
            if (done_at < 0 && bus_if.o_done === 1'b1) begin
                done_at = i;
                on_done();
            end
            if (done_at >= 0 && i > done_at && i >= FRAME - 1) break;
        end
        bus_if.i_rx = 1'b1;
        check("reply_done_seen", 32'(done_at >= 0), 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        int bad;
        rst_n           = 1'b0;
        bus_if.i_tick   = 1'b1;
        bus_if.i_start  = 1'b0;
        bus_if.i_rx     = 1'b1;
        bus_if.i_data_a = '0;
        bus_if.i_data_b = '0;
        bus_if.i_op     = '0;
        repeat (3) step();
        check("rst_tx", bus_if.o_tx, 1);
        check("rst_busy", bus_if.o_busy, 0);
        check("rst_done", bus_if.o_done, 0);
        check("rst_error", bus_if.o_error, 0);
        check("rst_result", bus_if.o_result, 0);
        rst_n = 1'b1;

        // nominal 5,3,0x20 -> reply 0x08
        start_txn(8'h05, 8'h03, 6'h20);
        collect_tx(-1);
        exp_res.push_back({1'b0, 8'h08});
        reply(8'h08, 1'b1, 40);

        // timeout: done 4096 ticks after opcode stop bit
        start_txn(8'h11, 8'h22, 6'h3f);
        collect_tx(-1);
        exp_res.push_back({1'b1, 8'h08});
        for (k = 1; k <= TO + 100; k++) begin
            step();
            if (bus_if.o_done === 1'b1) break;
        end
        check("timeout_ticks", k, TO);
        on_done();
        step();
        check("timeout_post_busy", bus_if.o_busy, 0);

        // framing error: 0xFF with stop bit 0
        start_txn(8'h5a, 8'ha5, 6'h01);
        collect_tx(-1);
        exp_res.push_back({1'b1, 8'h08});
        reply(8'hff, 1'b0, 40);

        // busy start pulse in SEND_A, then rx glitch, then 0x42
        start_txn(8'hc3, 8'h3c, 6'h2a);
        collect_tx(20);
        bad = 0;
        bus_if.i_rx = 1'b0;
        repeat (3) step();
        bus_if.i_rx = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (bus_if.o_done !== 1'b0) bad++;
        end
        check("glitch_no_done", bad, 0);
        exp_res.push_back({1'b0, 8'h42});
        reply(8'h42, 1'b1, 40);
        bad = 0;
        for (int i = 0; i < 600; i++) begin
            step();
            if (bus_if.o_tx !== 1'b1 || bus_if.o_busy !== 1'b0) bad++;
        end
        check("no_queued_txn", bad, 0);
        check("result_held", bus_if.o_result, 8'h42);

        // tick hold mid SEND_A, then async reset mid SEND_B
        start_txn(8'haa, 8'h00, 6'h01);
        repeat (100) step();
        check("pre_hold_tx", bus_if.o_tx, 1);
        bus_if.i_tick = 1'b0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus_if.o_tx !== 1'b1) bad++;
        end
        check("hold_tx", bad, 0);
        bus_if.i_tick = 1'b1;
        repeat (100) step();
        check("sendb_tx", bus_if.o_tx, 0);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_async_tx", bus_if.o_tx, 1);
        check("rst_async_busy", bus_if.o_busy, 0);
        exp_tx.delete();
        repeat (3) step();
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 600; i++) begin
            step();
            if (bus_if.o_tx !== 1'b1 || bus_if.o_done !== 1'b0) bad++;
        end
        check("post_reset_idle", bad, 0);

        // start accepted on the first edge after reset release
        rst_n = 1'b0;
        step();
        rst_n          = 1'b1;
        bus_if.i_start = 1'b1;
        step();
        bus_if.i_start = 1'b0;
        check("accept_after_reset", bus_if.o_busy, 1);
        check("start_bit_after_reset", bus_if.o_tx, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/alu_uart_host.md
ALU_UART_HOST -- requirements
Module: alu_uart_host

Interface
REQ-001 Parameter N_DATA, default 8: width of operand, result and UART data bytes.
REQ-002 Parameter NB_OPERATION, default 6: opcode width; the opcode is sent zero-extended to N_DATA bits.
REQ-003 Parameter N_OVERSAMPLE, default 16: baud ticks per serial bit.
REQ-004 Parameter TIMEOUT_TICKS, default 4096: ticks allowed between the end of the opcode stop bit and the result start bit.
REQ-005 i_clk  in  1  system clock; all state changes on its rising edge.
REQ-006 i_rst  in  1  reset, asynchronous, active-low.
REQ-007 i_tick  in  1  baud-rate strobe at N_OVERSAMPLE x bit rate; one-cycle pulse.
REQ-008 i_start  in  1  request pulse; accepted only when o_busy=0.
REQ-009 i_data_a  in  N_DATA  operand A; latched on accept.
REQ-010 i_data_b  in  N_DATA  operand B; latched on accept.
REQ-011 i_op  in  NB_OPERATION  opcode; latched on accept.
REQ-012 i_rx  in  1  serial input from the ALU target; idle high.
REQ-013 o_tx  out  1  serial output to the ALU target; idle high.
REQ-014 o_busy  out  1  high from the accept cycle until the cycle o_done pulses (inclusive).
REQ-015 o_done  out  1  one-cycle pulse ending every accepted transaction.
REQ-016 o_result  out  N_DATA  received result byte; valid while o_done=1 and held until the next o_done.
REQ-017 o_error  out  1  qualified by o_done: 1 = timeout or framing error, 0 = good result.

Function
REQ-018 Frame format SHALL be 8N1, LSB first: start bit 0, N_DATA data bits, stop bit 1; each bit lasts exactly N_OVERSAMPLE i_tick pulses.
REQ-019 FSM states SHALL be IDLE, SEND_A, SEND_B, SEND_OP, WAIT_RES, RECV, DONE.
REQ-020 IDLE -> SEND_A on i_start=1; the cycle after acceptance o_busy=1 and A, B and op are registered; later input changes are ignored.
REQ-021 SEND_A -> SEND_B -> SEND_OP SHALL proceed back-to-back, with the next start bit beginning on the tick after the previous stop bit ends and no idle gap.
REQ-022 SEND_OP -> WAIT_RES after the opcode stop bit; o_tx SHALL then stay 1 until the next transaction.
REQ-023 WAIT_RES SHALL count ticks; i_rx=0 on a tick -> RECV; count reaching TIMEOUT_TICKS -> DONE with o_error=1 and o_result unchanged.
REQ-024 RECV SHALL recheck i_rx at tick N_OVERSAMPLE/2 after the start edge; if i_rx=1 it is a glitch -> back to WAIT_RES (timeout counter not reset); otherwise sample each data bit and the stop bit every N_OVERSAMPLE ticks after that midpoint.
REQ-025 Stop bit sampled 0 -> DONE with o_error=1; stop bit 1 -> DONE with o_error=0 and o_result updated.
REQ-026 DONE SHALL last one cycle (o_done=1), then -> IDLE with o_busy=0; i_start in the DONE cycle SHALL be ignored.
REQ-027 i_start while o_busy=1 SHALL be ignored with no queuing.
REQ-028 i_rx activity outside WAIT_RES/RECV SHALL be ignored.
REQ-029 Bit and tick counters SHALL advance only on i_tick; with i_tick=0 all state, including o_tx, SHALL hold.
REQ-030 Every o_tx bit and the i_rx input SHALL be registered; i_rx SHALL pass through a 2-flop synchronizer before use.

Reset
REQ-031 i_rst=0 SHALL immediately force state IDLE, o_tx=1, o_busy=0, o_done=0, o_error=0, o_result=0, and all counters and latches to 0, independent of i_clk.
REQ-032 Reset during any state, including mid-bit, SHALL abort the transaction without an o_done pulse.
REQ-033 After i_rst returns high, the first acceptable i_start SHALL be on the following rising edge.

Verification
REQ-034 Reset: assert i_rst=0 mid-SEND_B -> o_tx=1, o_busy=0 with no clock edge; after release and with no stimulus, o_tx stays 1.
REQ-035 Nominal (i_tick tied 1, N_OVERSAMPLE=16): start with A=0x05, B=0x03, op=0x20 -> o_tx carries bytes 0x05, 0x03, 0x20 over 480 consecutive cycles; reply 0x08 on i_rx -> o_done=1, o_error=0, o_result=0x08.
REQ-036 Timeout: no reply after the opcode -> o_done=1, o_error=1 exactly 4096 ticks after the opcode stop bit ends; o_result keeps its previous value.
REQ-037 Framing error: reply 0xFF with stop bit 0 -> o_done=1, o_error=1, o_result unchanged.
REQ-038 Busy/glitch: i_start pulse during SEND_A is ignored (one transaction only); a 3-tick low glitch on i_rx in WAIT_RES -> no RECV, and a valid 0x42 afterwards yields o_result=0x42.
